spi_config_sequencer: RTL and testbench

- SPI controller that configures the on-chip SPI register file (output enables, PWM enables, PWM duty cycle) from a queued list of register writes.
- Accepts (address, data) write commands on a valid/ready interface, buffers them in a small FIFO, and serialises each one as a 16-bit write frame on cs/SCLK/COPI.
- Sits between the host-side control logic (bring-up sequencer, test controller) and the SPI peripheral pins.

---
 rtl/spi_config_sequencer_if.sv | 9 +
 rtl/spi_config_sequencer.sv | 145 ++++++++++++++
 tb/tb_spi_config_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/spi_config_sequencer_if.sv
// spi_config_sequencer_if: valid/ready command channel carrying one register write (addr, data).
interface spi_config_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;
    modport master (output cmd_valid, cmd_addr, cmd_data, input cmd_ready);
    modport slave (input cmd_valid, cmd_addr, cmd_data, output cmd_ready);
endinterface

// File: rtl/spi_config_sequencer.sv
// spi_config_sequencer: queues register writes in a FIFO and serialises each as a 16-bit SPI write frame.
// Optional macro SPI_ADDR_FILTER_EN drops commands with addr > 4 at accept time and pulses err.
module spi_config_sequencer #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2,
    parameter int CS_GAP     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    spi_config_sequencer_if.slave         cmd,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err,
    output logic                          cs,
    output logic                          SCLK,
    output logic                          COPI
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;
    state_e        state_q, state_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [14:0]   mem_q [FIFO_DEPTH];
    logic [14:0]   shift_q, shift_d;
    logic [7:0]    phase_q, phase_d;
    logic [4:0]    bit_q, bit_d;
    logic          cs_q, cs_d, sclk_q, sclk_d, copi_q, copi_d;
    logic          done_q, done_d, err_q, err_d;
    logic          accept, drop, push, pop;
    logic [14:0]   head;
    logic [15:0]   frame;
    assign accept = cmd.cmd_valid && cmd.cmd_ready;
`ifdef SPI_ADDR_FILTER_EN
    assign drop = accept && (cmd.cmd_addr > 7'd4);
`else
    assign drop = 1'b0;
`endif
    assign push  = accept && !drop;
    assign pop   = (state_q == IDLE) && (cnt_q != '0);
    assign head  = mem_q[rd_q];
    assign frame = {head[7:0], head[14:8], 1'b1};
    assign cmd.cmd_ready = cnt_q != (AW+1)'(FIFO_DEPTH);
    assign busy       = (cnt_q != '0) || (state_q != IDLE);
    assign fifo_level = cnt_q;
    assign done       = done_q;
    assign err        = err_q;
    assign cs         = cs_q;
    assign SCLK       = sclk_q;
    assign COPI       = copi_q;
    always_comb begin
        wr_d  = push ? wr_q + AW'(1) : wr_q;
        rd_d  = pop ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        err_d = drop;
    end
    always_comb begin
        state_d = state_q;
        phase_d = phase_q + 8'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        copi_d  = copi_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (pop) begin
                    state_d = SETUP;
                    shift_d = frame[15:1];
                    copi_d  = frame[0];
                    cs_d    = 1'b0;
                    bit_d   = '0;
                end
            end
            SETUP: if (phase_q == 8'(CS_SETUP - 1)) begin
                state_d = SHIFT;
                phase_d = '0;
                bit_d   = '0;
            end
            SHIFT: if (phase_q == 8'(CLK_DIV - 1)) begin
                phase_d = '0;
                sclk_d  = !sclk_q;
                // data only advances as SCLK falls, so COPI is steady across every high phase
                if (sclk_q) begin
                    if (bit_q == 5'd15) begin
                        state_d = HOLD;
                        bit_d   = '0;
                    end else begin
                        bit_d   = bit_q + 5'd1;
                        copi_d  = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            HOLD: if (phase_q == 8'(CS_HOLD - 1)) begin
                state_d = GAP;
                phase_d = '0;
                cs_d    = 1'b1;
                copi_d  = 1'b0;
                done_d  = 1'b1;
            end
            GAP: if (phase_q == 8'(CS_GAP - 1)) begin
                state_d = IDLE;
                phase_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            phase_q <= '0;
            bit_q   <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {cmd.cmd_addr, cmd.cmd_data};
    end
endmodule

// File: tb/tb_spi_config_sequencer.sv
// tb_spi_config_sequencer: directed and random register writes checked against a peripheral model
// that decodes frames off the pins and a queue of the writes expected to reach it.
module tb_spi_config_sequencer;
    localparam int CLK_DIV = 4, FIFO_DEPTH = 4, CS_SETUP = 2, CS_HOLD = 2, CS_GAP = 4;
    localparam int CS_LOW = CS_SETUP + 32 * CLK_DIV + CS_HOLD;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, done, err, cs, sclk, copi;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    spi_config_sequencer_if ifc ();
    spi_config_sequencer #(
        .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd(ifc), .busy(busy), .done(done), .fifo_level(fifo_level),
        .err(err), .cs(cs), .SCLK(sclk), .COPI(copi)
    );
    always #5 clk = ~clk;
    int tests = 0, fails = 0;
    logic [14:0] exp_q[$];
    logic [7:0]  regs [128];
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask
    // peripheral model: samples COPI on SCLK rises while cs is low, applies the write when cs rises
    int lo_run, gap_run, ph_run, rises, frames = 0, dones = 0;
    logic [15:0] bits, last_frame;
    logic in_frame = 1'b0, had_frame = 1'b0, seen_fall, unstable, hi_val, p_cs = 1'b1, p_sclk = 1'b0;
    logic [14:0] e;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0; had_frame = 1'b0; p_cs = 1'b1; p_sclk = 1'b0; gap_run = 0;
        end else begin
            if (done) dones++;
            if (done || (cs && !p_cs && in_frame)) chk("done_pulse", done, cs && !p_cs && in_frame);
            if (!cs) begin
                if (p_cs) begin
                    if (had_frame) chk("cs_gap", gap_run >= CS_GAP + 1, 1);
                    chk("copi_first", copi, 1);
                    in_frame = 1'b1; lo_run = 0; rises = 0; seen_fall = 1'b0; ph_run = 0; bits = '0;
                end
                lo_run++;
                if (sclk != p_sclk) begin
                    if (sclk) begin
                        if (seen_fall) chk("sclk_low", ph_run, CLK_DIV);
                        if (rises < 16) bits[rises] = copi;
                        rises++; hi_val = copi; unstable = 1'b0;
                    end else begin
                        chk("sclk_high", ph_run, CLK_DIV);
                        chk("copi_stable", unstable, 0);
                        seen_fall = 1'b1;
                    end
                    ph_run = 0;
                end
                ph_run++;
                if (sclk && copi !== hi_val) unstable = 1'b1;
            end else begin
                if (!p_cs && in_frame) begin
                    chk("cs_low_len", lo_run, CS_LOW);
                    chk("sclk_rises", rises, 16);
                    chk("sclk_idle", sclk, 0);
                    chk("copi_idle", copi, 0);
                    chk("write_flag", bits[0], 1);
                    chk("frame_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("frame_addr", bits[7:1], e[14:8]);
                        chk("frame_data", bits[15:8], e[7:0]);
                    end
                    regs[bits[7:1]] = bits[15:8];
                    last_frame = bits; frames++;
                    in_frame = 1'b0; had_frame = 1'b1; gap_run = 0;
                end
                gap_run++;
            end
            p_cs = cs; p_sclk = sclk;
        end
    end
    task automatic send(input logic [6:0] a, input logic [7:0] d);
        int n = 0;
        logic drop;
        @(negedge clk);
        ifc.cmd_valid = 1'b1; ifc.cmd_addr = a; ifc.cmd_data = d;
        while (!ifc.cmd_ready && n < 2000) begin @(negedge clk); n++; end
        chk("ready_timeout", ifc.cmd_ready, 1);
        @(posedge clk);
        #1 ifc.cmd_valid = 1'b0;
`ifdef SPI_ADDR_FILTER_EN
        drop = a > 7'd4;
`else
        drop = 1'b0;
`endif
        chk("err", err, drop);
        if (!drop) exp_q.push_back({a, d});
    endtask
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || in_frame) && n < 20000) begin @(negedge clk); n++; end
        chk("idle_timeout", busy, 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask
    int f0, d0, n;
    initial begin
        foreach (regs[i]) regs[i] = 8'h00;
        ifc.cmd_valid = 1'b0; ifc.cmd_addr = '0; ifc.cmd_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_cs", cs, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_copi", copi, 0);
        chk("rst_ready", ifc.cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        // single write: cs falls on the second edge counted from the cycle valid is raised
        f0 = frames; d0 = dones;
        send(7'd4, 8'h80);
        chk("cs_before_fall", cs, 1);
        chk("busy_after_accept", busy, 1);
        @(posedge clk);
        #1 chk("cs_fall", cs, 0);
        wait_idle();
        chk("single_frames", frames - f0, 1);
        chk("single_dones", dones - d0, 1);
        chk("single_bits", last_frame, 16'h8009);
        chk("pwm_duty", regs[4], 8'h80);
        // back-to-back burst fills the FIFO while the first frame is in flight
        f0 = frames;
        for (int i = 0; i < 6; i++) begin
            send(7'(i), 8'(8'h11 * (i + 1)));
            if (i == 3) chk("level_after_4", fifo_level, 3);
            if (i == 4) begin
                chk("ready_full", ifc.cmd_ready, 0);
                chk("level_full", fifo_level, 4);
            end
        end
        wait_idle();
        chk("burst_frames", frames - f0, 6);
        chk("burst_reg5", regs[5], 8'h66);
        // reset in the middle of a frame with another command still queued
        send(7'd1, 8'hA5);
        send(7'd2, 8'h5A);
        n = 0;
        while (!(in_frame && rises == 7) && n < 3000) begin @(negedge clk); n++; end
        chk("rise7_timeout", rises, 7);
        d0 = dones; f0 = frames;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cs", cs, 1);
        chk("arst_sclk", sclk, 0);
        chk("arst_level", fifo_level, 0);
        chk("arst_busy", busy, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst_no_done", dones - d0, 0);
        chk("arst_no_frame", frames - f0, 0);
        send(7'd3, 8'h3C);
        wait_idle();
        chk("post_rst_reg", regs[3], 8'h3C);
        // filtered address followed by a legal one
        send(7'd5, 8'hFF);
        send(7'd0, 8'hFF);
        wait_idle();
        chk("en_reg", regs[0], 8'hFF);
        // random traffic with random idle gaps
        f0 = frames;
        for (int i = 0; i < 20; i++) begin
`ifdef SPI_ADDR_FILTER_EN
            send(7'($urandom_range(0, 4)), 8'($urandom));
`else
            send(7'($urandom_range(0, 127)), 8'($urandom));
`endif
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        wait_idle();
        chk("random_frames", frames - f0, 20);
        chk("dones_match", dones, frames);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
